// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU port and a DMA/loader port share one memory
// port through a round-robin FSM with registered outputs and a granted-cycle timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [1:0]  c_width,
    input  logic        c_read,
    input  logic        c_write,
    output logic [31:0] c_rdata,
    output logic        c_ok,
    output logic        c_err,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_width,
    input  logic        d_read,
    input  logic        d_write,
    output logic [31:0] d_rdata,
    output logic        d_ok,
    output logic        d_err,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_width,
    output logic        m_read,
    output logic        m_write,
    input  logic [31:0] m_rdata,
    input  logic        m_ok
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GNT_C = 2'd1;
    localparam logic [1:0] S_GNT_D = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic GRANT_C = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // Abort fires on the edge where the counter would step onto TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

    logic [1:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [1:0]  m_width_q, m_width_d;
    logic        m_read_q, m_read_d;
    logic        m_write_q, m_write_d;

    logic [31:0] c_rdata_q, c_rdata_d;
    logic        c_ok_q, c_ok_d;
    logic        c_err_q, c_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_ok_q, d_ok_d;
    logic        d_err_q, d_err_d;

    logic        c_pend_s;
    logic        d_pend_s;
    logic        pick_d_s;
    logic        gnt_is_d_s;

    assign c_pend_s   = c_read | c_write;
    assign d_pend_s   = d_read | d_write;
    // DMA wins only when alone or when the CPU held the previous grant.
    assign pick_d_s   = d_pend_s & (~c_pend_s | (last_grant_q == GRANT_C));
    assign gnt_is_d_s = (state_q == S_GNT_D);

    // Next-state and output-register logic for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_width_d    = m_width_q;
        m_read_d     = m_read_q;
        m_write_d    = m_write_q;
        c_rdata_d    = c_rdata_q;
        d_rdata_d    = d_rdata_q;
        c_ok_d       = 1'b0;
        c_err_d      = 1'b0;
        d_ok_d       = 1'b0;
        d_err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (c_pend_s || d_pend_s) begin
                    cnt_d = 8'd0;
                    if (pick_d_s) begin
                        m_addr_d     = d_addr;
                        m_wdata_d    = d_wdata;
                        m_width_d    = d_width;
                        m_read_d     = d_read & ~d_write;
                        m_write_d    = d_write;
                        last_grant_d = GRANT_D;
                        state_d      = S_GNT_D;
                    end else begin
                        m_addr_d     = c_addr;
                        m_wdata_d    = c_wdata;
                        m_width_d    = c_width;
                        m_read_d     = c_read & ~c_write;
                        m_write_d    = c_write;
                        last_grant_d = GRANT_C;
                        state_d      = S_GNT_C;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_GNT_C, S_GNT_D: begin
                if (m_ok) begin
                    // Completion takes priority over a coincident timeout.
                    if (gnt_is_d_s) begin
                        d_ok_d = 1'b1;
                        if (m_read_q) begin
                            d_rdata_d = m_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        c_ok_d = 1'b1;
                        if (m_read_q) begin
                            c_rdata_d = m_rdata;
                        end else begin
                            c_rdata_d = c_rdata_q;
                        end
                    end
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    state_d   = S_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (gnt_is_d_s) begin
                        d_ok_d  = 1'b1;
                        d_err_d = 1'b1;
                    end else begin
                        c_ok_d  = 1'b1;
                        c_err_d = 1'b1;
                    end
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_D;
            cnt_q        <= 8'd0;
            m_addr_q     <= 32'd0;
            m_wdata_q    <= 32'd0;
            m_width_q    <= 2'd0;
            m_read_q     <= 1'b0;
            m_write_q    <= 1'b0;
            c_rdata_q    <= 32'd0;
            c_ok_q       <= 1'b0;
            c_err_q      <= 1'b0;
            d_rdata_q    <= 32'd0;
            d_ok_q       <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_width_q    <= m_width_d;
            m_read_q     <= m_read_d;
            m_write_q    <= m_write_d;
            c_rdata_q    <= c_rdata_d;
            c_ok_q       <= c_ok_d;
            c_err_q      <= c_err_d;
            d_rdata_q    <= d_rdata_d;
            d_ok_q       <= d_ok_d;
            d_err_q      <= d_err_d;
        end
    end

    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_width = m_width_q;
    assign m_read  = m_read_q;
    assign m_write = m_write_q;
    assign c_rdata = c_rdata_q;
    assign c_ok    = c_ok_q;
    assign c_err   = c_err_q;
    assign d_rdata = d_rdata_q;
    assign d_ok    = d_ok_q;
    assign d_err   = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: expected grants and completions are
// queued when a request is raised and checked when the arbiter acts on it.
module tb_mem_arbiter;

    localparam int   TO = 4;
    localparam logic PC = 1'b0;
    localparam logic PD = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [1:0]  c_width;
    logic        c_read, c_write, c_ok, c_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_width;
    logic        d_read, d_write, d_ok, d_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_width;
    logic        m_read, m_write, m_ok;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_width(c_width),
        .c_read(c_read), .c_write(c_write),
        .c_rdata(c_rdata), .c_ok(c_ok), .c_err(c_err),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width),
        .d_read(d_read), .d_write(d_write),
        .d_rdata(d_rdata), .d_ok(d_ok), .d_err(d_err),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width),
        .m_read(m_read), .m_write(m_write),
        .m_rdata(m_rdata), .m_ok(m_ok)
    );

    typedef struct {
        logic        port;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    txn_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_c_rdata = 32'd0;
    logic [31:0] exp_d_rdata = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic port, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] width,
                       input logic [31:0] rdata, input logic err);
        txn_t t;
        t.port = port; t.rd = rd; t.wr = wr; t.addr = addr;
        t.wdata = wdata; t.width = width; t.rdata = rdata; t.err = err;
        sb.push_back(t);
        if (port == PD) begin
            d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata; d_width = width;
        end else begin
            c_read = rd; c_write = wr; c_addr = addr; c_wdata = wdata; c_width = width;
        end
    endtask

    // lat=0: memory never answers (timeout); glitch: raise the other port for one granted cycle.
    task automatic run_txn(input int lat, input bit drop_early, input bit glitch);
        txn_t t;
        int   cyc;
        int   gnt_cycles;
        cyc = 0;
        while (!(m_read || m_write) && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant_seen", 32'(m_read | m_write), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        t = sb.pop_front();
        chk("m_addr", m_addr, t.addr);
        chk("m_wdata", m_wdata, t.wdata);
        chk("m_width", 32'(m_width), 32'(t.width));
        chk("m_read", 32'(m_read), 32'(t.rd & ~t.wr));
        chk("m_write", 32'(m_write), 32'(t.wr));
        m_rdata = t.rdata;
        if (drop_early) begin
            if (t.port == PD) begin d_read = 1'b0; d_write = 1'b0; end
            else begin c_read = 1'b0; c_write = 1'b0; end
        end
        if (glitch) begin
            if (t.port == PD) begin c_read = 1'b1; c_addr = 32'hBAD0_0000; end
            else begin d_read = 1'b1; d_addr = 32'hBAD0_0000; end
        end
        if (lat > 0) begin
            for (int k = 1; k < lat; k++) begin
                @(negedge clk);
                if (glitch) begin
                    if (t.port == PD) c_read = 1'b0;
                    else d_read = 1'b0;
                end
            end
            m_ok = 1'b1;
            @(negedge clk);
            m_ok = 1'b0;
            m_rdata = 32'hDEAD_BEEF;
        end else begin
            gnt_cycles = 0;
            while (!(c_ok || d_ok) && gnt_cycles < 300) begin
                if (m_read || m_write) gnt_cycles++;
                else gnt_cycles += 100;
                @(negedge clk);
            end
            chk("timeout_cycles", 32'(gnt_cycles), 32'(TO));
        end
        chk("own_ok", 32'(t.port == PD ? d_ok : c_ok), 32'd1);
        chk("own_err", 32'(t.port == PD ? d_err : c_err), 32'(t.err));
        chk("other_ok", 32'(t.port == PD ? c_ok : d_ok), 32'd0);
        chk("other_err", 32'(t.port == PD ? c_err : d_err), 32'd0);
        if (t.rd && !t.wr && !t.err) begin
            if (t.port == PD) exp_d_rdata = t.rdata;
            else exp_c_rdata = t.rdata;
        end
        chk("c_rdata", c_rdata, exp_c_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        chk("m_cmd_cleared", 32'({m_read, m_write}), 32'd0);
        if (t.port == PD) begin d_read = 1'b0; d_write = 1'b0; end
        else begin c_read = 1'b0; c_write = 1'b0; end
        @(negedge clk);
        chk("ok_single_pulse", 32'({c_ok, c_err, d_ok, d_err}), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        c_addr = 32'd0; c_wdata = 32'd0; c_width = 2'd0; c_read = 1'b0; c_write = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; d_width = 2'd0; d_read = 1'b0; d_write = 1'b0;
        m_rdata = 32'd0; m_ok = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_cmd", 32'({m_read, m_write}), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_width", 32'(m_width), 32'd0);
        chk("rst_flags", 32'({c_ok, c_err, d_ok, d_err}), 32'd0);
        chk("rst_c_rdata", c_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;

        // Both ports pending from reset: C, D, C, D with 1-cycle memory latency.
        req(PC, 1'b0, 1'b1, 32'hC000_0010, 32'h1111_0001, 2'd2, 32'h0F0F_0001, 1'b0);
        req(PD, 1'b0, 1'b1, 32'hD000_0020, 32'h2222_0002, 2'd2, 32'h0F0F_0002, 1'b0);
        run_txn(1, 1'b0, 1'b0);
        req(PC, 1'b0, 1'b1, 32'hC000_0030, 32'h3333_0003, 2'd1, 32'h0F0F_0003, 1'b0);
        run_txn(1, 1'b0, 1'b0);
        req(PD, 1'b0, 1'b1, 32'hD000_0040, 32'h4444_0004, 2'd0, 32'h0F0F_0004, 1'b0);
        run_txn(1, 1'b0, 1'b0);
        run_txn(1, 1'b0, 1'b0);

        // CPU word read, memory answers three cycles after m_read.
        req(PC, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 2'd2, 32'h1234_5678, 1'b0);
        run_txn(3, 1'b0, 1'b0);

        // DMA read whose request drops right after grant still completes.
        req(PD, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0000, 2'd2, 32'hA5A5_0001, 1'b0);
        run_txn(2, 1'b1, 1'b0);

        // DMA write with memory silent: abort after TO granted cycles, d_rdata kept.
        req(PD, 1'b0, 1'b1, 32'h0000_3000, 32'hCAFE_0005, 2'd2, 32'h7777_7777, 1'b1);
        run_txn(0, 1'b0, 1'b0);

        // m_ok on the exact timeout cycle is a normal completion.
        req(PC, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_0000, 2'd2, 32'h0BAD_F00D, 1'b0);
        run_txn(TO, 1'b0, 1'b0);

        // Read+write together is a write; half width and wdata pass through.
        req(PC, 1'b1, 1'b1, 32'h0000_5002, 32'h5555_AAAA, 2'd1, 32'h6666_6666, 1'b0);
        run_txn(2, 1'b0, 1'b0);

        // DMA request raised and dropped while the CPU is granted is lost.
        req(PC, 1'b0, 1'b1, 32'h0000_6000, 32'h6060_6060, 2'd2, 32'h0000_0000, 1'b0);
        run_txn(2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dropped_req_no_grant", 32'({m_read, m_write}), 32'd0);
        end

        // Reset during GNT_D aborts silently; CPU wins the next conflict.
        d_write = 1'b1; d_addr = 32'hD000_7000; d_wdata = 32'h7070_7070; d_width = 2'd2;
        @(negedge clk);
        chk("pre_rst_gnt_d", m_addr, 32'hD000_7000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_m_cmd", 32'({m_read, m_write}), 32'd0);
        chk("post_rst_no_ok", 32'({c_ok, c_err, d_ok, d_err}), 32'd0);
        chk("post_rst_c_rdata", c_rdata, 32'd0);
        chk("post_rst_d_rdata", d_rdata, 32'd0);
        exp_c_rdata = 32'd0;
        exp_d_rdata = 32'd0;
        req(PC, 1'b1, 1'b0, 32'hC000_8000, 32'h0000_0000, 2'd2, 32'h8888_0008, 1'b0);
        req(PD, 1'b0, 1'b1, 32'hD000_7000, 32'h7070_7070, 2'd2, 32'h9999_0009, 1'b0);
        run_txn(1, 1'b0, 1'b0);
        run_txn(2, 1'b0, 1'b0);

        // Stray m_ok while idle is ignored.
        m_ok = 1'b1; m_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        m_ok = 1'b0;
        @(negedge clk);
        chk("idle_m_ok_ignored", 32'({c_ok, c_err, d_ok, d_err}), 32'd0);
        chk("idle_c_rdata", c_rdata, exp_c_rdata);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of granted cycles without m_ok before a transaction aborts; the legal range is 2..255.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 c_addr  input  32  CPU byte address.
REQ-005 c_wdata  input  32  CPU write data.
REQ-006 c_width  input  2  CPU access width (0=byte, 1=half, 2=word), passed through unchanged.
REQ-007 c_read / c_write  input  1 each  CPU request levels, held until c_ok.
REQ-008 c_rdata  output  32  CPU read data, registered.
REQ-009 c_ok / c_err  output  1 each  CPU completion pulse / abort flag.
REQ-010 d_addr, d_wdata, d_width, d_read, d_write, d_rdata, d_ok, d_err are the DMA/loader port, identical to REQ-004..REQ-009.
REQ-011 m_addr  output  32  memory address; m_wdata  output  32; m_width  output  2.
REQ-012 m_read / m_write  output  1 each  memory command levels.
REQ-013 m_rdata  input  32  memory read data, valid while m_ok is high.
REQ-014 m_ok  input  1  memory completion pulse.

Function
REQ-015 The FSM states are IDLE, GNT_C, GNT_D and DONE; all outputs are registered.
REQ-016 A port is pending when its read or write is high; if both are high, the access is treated as a write, with m_read=0 and m_write=1.
REQ-017 IDLE with exactly one pending port: the arbiter latches that port's addr, wdata, width and command into the m_* registers and moves to GNT_C or GNT_D, so the command appears on m_* one cycle after the request is sampled.
REQ-018 IDLE with both ports pending: the grant goes to the port not in last_grant (round-robin); last_grant is updated on every grant.
REQ-019 In GNT_x, m_* outputs stay constant until completion; requester inputs are not re-sampled.
REQ-020 In GNT_x with m_ok=1: the arbiter latches m_rdata into x_rdata (read transactions only), pulses x_ok=1 for exactly one cycle, clears m_read/m_write and moves to DONE, all in the same edge.
REQ-021 DONE lasts one cycle, ignores all requests, then returns to IDLE; a requester drops its request in the cycle its ok is high.
REQ-022 The timeout counter (8 bits) clears on grant and increments in each GNT cycle with m_ok=0.
REQ-023 When the counter reaches TIMEOUT: m_read/m_write clear, x_ok and x_err both pulse for one cycle, x_rdata holds its previous value, and the FSM moves to DONE.
REQ-024 m_ok is ignored in IDLE and DONE.
REQ-025 If m_ok arrives in the same cycle the counter reaches TIMEOUT, it is a normal completion with x_err=0.
REQ-026 The non-granted port's ok, err and rdata hold (ok/err=0) for the whole transaction.
REQ-027 A request deasserted while waiting (before grant) is dropped silently; one deasserted during GNT is still completed.
REQ-028 Back-to-back throughput is at most one transaction per 3 cycles plus memory latency.

Reset
REQ-029 While rst=1 at an edge, the arbiter sets: state=IDLE, last_grant=D (so the CPU wins the first conflict), counter=0, m_read=m_write=0, m_addr=m_wdata=0, m_width=0, c_ok=c_err=d_ok=d_err=0, c_rdata=d_rdata=0.
REQ-030 Reset mid-transaction aborts it with no ok/err pulse, and m_read/m_write read 0 in the first cycle after reset.

Verification
REQ-031 CPU word read of 0x0000_1000; memory pulses m_ok with m_rdata=0x1234_5678 three cycles after m_read -> c_rdata=0x1234_5678, a single-cycle c_ok, d_ok=0.
REQ-032 Both ports pending from reset, each write completing with 1-cycle memory latency -> grants C, D, C, D in order, and m_write never stays high across a DONE cycle.
REQ-033 DMA write with m_ok held low, TIMEOUT=4 -> m_write drops after 4 granted cycles, d_ok=d_err=1 for one cycle, d_rdata unchanged.
REQ-034 m_ok arrives on the exact timeout cycle -> c_ok=1, c_err=0.
REQ-035 rst asserted during GNT_D -> next cycle state=IDLE, m_write=0, no d_ok; a following CPU read is granted first.
REQ-036 c_read=c_write=1 with c_width=1 -> m_write=1, m_read=0, m_width=1, m_wdata=c_wdata.
